// File: rtl/fire_layer_sequencer_pkg.sv
// Shared definitions for fire-layer sequencers: FSM state encoding and
// geometry helpers that size counters and address buses.
package fire_layer_sequencer_pkg;

  typedef logic [2:0] layer_state_t;

  localparam layer_state_t ST_IDLE     = 3'd0;
  localparam layer_state_t ST_RUN      = 3'd1;
  localparam layer_state_t ST_DRAIN    = 3'd2;
  localparam layer_state_t ST_FEEDBACK = 3'd3;
  localparam layer_state_t ST_DONE     = 3'd4;

  function automatic int k2c(input int kernelDim, input int chin);
    return kernelDim * kernelDim * chin;
  endfunction

  // Never returns zero so that degenerate geometries still get a 1-bit bus.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_addr_gen.sv
// Im2col read-address generator: walks pixel p and tap k with one bubble tap
// per pixel, building p*K2C+k by increments only.
module layer_addr_gen
  import fire_layer_sequencer_pkg::*;
#(
  parameter int NPIX = 4,
  parameter int K2C  = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_i,
  input  logic                            en_i,
  output logic                            rd_o,
  output logic [addrWidth(NPIX*K2C)-1:0]  addr_o,
  output logic                            last_o
);

  localparam int AW = addrWidth(NPIX * K2C);
  localparam int PW = addrWidth(NPIX);
  localparam int KW = addrWidth(K2C + 1);
  localparam logic [PW-1:0] P_LAST    = PW'(NPIX - 1);
  localparam logic [KW-1:0] K_BUBBLE  = KW'(K2C);
  localparam logic [KW-1:0] K_LASTTAP = KW'(K2C - 1);

  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          bubble;

  assign bubble = (k_q == K_BUBBLE);
  assign last_o = en_i && bubble && (p_q == P_LAST);
  assign rd_o   = en_i && !bubble;
  assign addr_o = addr_q;

  // The address holds through the bubble tap and freezes after the last one.
  always_comb begin
    p_d    = p_q;
    k_d    = k_q;
    addr_d = addr_q;
    if (clear_i) begin
      p_d    = '0;
      k_d    = '0;
      addr_d = '0;
    end else if (en_i && !last_o) begin
      if (bubble) begin
        k_d    = '0;
        p_d    = p_q + PW'(1);
        addr_d = addr_q + AW'(1);
      end else if (k_q == K_LASTTAP) begin
        k_d = K_BUBBLE;
      end else begin
        k_d    = k_q + KW'(1);
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      k_q    <= '0;
      addr_q <= '0;
    end else begin
      p_q    <= p_d;
      k_q    <= k_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/fire_layer_sequencer.sv
// Sequencer for one fire-layer pass: runs the conv datapath, collects output
// pixel samples into the output RAM, then signals feedback and completion.
module fire_layer_sequencer
  import fire_layer_sequencer_pkg::*;
#(
  parameter int WOUT       = 64,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3,
  parameter int DRAIN_MAX  = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start_i,
  input  logic                                                  layer_sample_i,
  output logic                                                  layer_en_o,
  output logic                                                  ifm_rd_o,
  output logic [addrWidth(WOUT*WOUT*k2c(KERNEL_DIM, CHIN))-1:0] ifm_addr_o,
  output logic                                                  ofm_we_o,
  output logic [addrWidth(WOUT*WOUT)-1:0]                       ofm_addr_o,
  output logic                                                  ram_feedback_o,
  output logic                                                  busy_o,
  output logic                                                  done_o,
  output logic                                                  err_o
);

  localparam int K2C  = k2c(KERNEL_DIM, CHIN);
  localparam int NPIX = WOUT * WOUT;
  localparam int OAW  = addrWidth(NPIX);
  localparam int SCW  = addrWidth(NPIX + 1);
  localparam int DCW  = addrWidth(DRAIN_MAX + 1);
  localparam logic [SCW-1:0] SAMP_FULL   = SCW'(NPIX);
  localparam logic [DCW-1:0] DRAIN_LIMIT = DCW'(DRAIN_MAX);

  layer_state_t   state_q, state_d;
  logic [SCW-1:0] samp_q, samp_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [OAW-1:0] ofm_addr_q, ofm_addr_d;
  logic           err_q, err_d;
  logic           we_q, we_d;
  logic           accept, run, collect, run_last, drain_timeout;

  assign accept  = (state_q == ST_IDLE) && start_i;
  assign run     = (state_q == ST_RUN);
  assign collect = run || (state_q == ST_DRAIN);

  layer_addr_gen #(
    .NPIX (NPIX),
    .K2C  (K2C)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .en_i    (run),
    .rd_o    (ifm_rd_o),
    .addr_o  (ifm_addr_o),
    .last_o  (run_last)
  );

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    drain_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          drain_d = '0;
        end
      end
      ST_RUN: begin
        if (run_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (samp_q == SAMP_FULL) begin
          state_d = ST_FEEDBACK;
        end else begin
          drain_d = drain_q + DCW'(1);
          if (drain_d == DRAIN_LIMIT) begin
            drain_timeout = 1'b1;
            state_d       = ST_FEEDBACK;
          end
        end
      end
      ST_FEEDBACK: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // A sample at saturation is an error and never reaches the output RAM.
  always_comb begin
    samp_d     = samp_q;
    we_d       = 1'b0;
    ofm_addr_d = ofm_addr_q;
    err_d      = err_q;
    if (accept) begin
      samp_d = '0;
      err_d  = 1'b0;
    end else if (collect && layer_sample_i) begin
      if (samp_q == SAMP_FULL) begin
        err_d = 1'b1;
      end else begin
        we_d       = 1'b1;
        ofm_addr_d = samp_q[OAW-1:0];
        samp_d     = samp_q + SCW'(1);
      end
    end
    if (drain_timeout && (samp_d != SAMP_FULL)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      samp_q     <= '0;
      drain_q    <= '0;
      ofm_addr_q <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      drain_q    <= drain_d;
      ofm_addr_q <= ofm_addr_d;
      err_q      <= err_d;
      we_q       <= we_d;
    end
  end

  assign layer_en_o     = run;
  assign busy_o         = (state_q != ST_IDLE);
  assign ram_feedback_o = (state_q == ST_FEEDBACK);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = err_q;
  assign ofm_we_o       = we_q;
  assign ofm_addr_o     = ofm_addr_q;

endmodule

// File: tb/tb_fire_layer_sequencer.sv
// Self-checking bench for fire_layer_sequencer at WOUT=2, CHIN=1, KERNEL_DIM=1:
// table-driven passes, randomized passes against a cycle model, reset abort.
module tb_fire_layer_sequencer;

  localparam int WOUT       = 2;
  localparam int CHIN       = 1;
  localparam int KERNEL_DIM = 1;
  localparam int DRAIN_MAX  = 16;
  localparam int K2C        = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int NPIX       = WOUT * WOUT;
  localparam int NRUN       = NPIX * (K2C + 1);

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_FB    = 3;
  localparam int PH_DONE  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_i = 1'b0;
  logic layer_sample_i = 1'b0;
  logic layerEn, ifmRd, ofmWe, ramFb, busy, done, err;
  logic [$clog2(NPIX*K2C)-1:0] ifmAddr;
  logic [$clog2(NPIX)-1:0]     ofmAddr;

  int nCompared = 0;
  int nMismatched = 0;
  int modelIfmAddr = 0;
  int modelOfmAddr = 0;

  typedef struct {
    logic [31:0] mask;
    bit          startNoise;
    int          expDrain;
    int          expWrites;
    bit          expErr;
  } passVec_t;

  fire_layer_sequencer #(
    .WOUT       (WOUT),
    .CHIN       (CHIN),
    .KERNEL_DIM (KERNEL_DIM),
    .DRAIN_MAX  (DRAIN_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .layer_sample_i (layer_sample_i),
    .layer_en_o     (layerEn),
    .ifm_rd_o       (ifmRd),
    .ifm_addr_o     (ifmAddr),
    .ofm_we_o       (ofmWe),
    .ofm_addr_o     (ofmAddr),
    .ram_feedback_o (ramFb),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".en"}, int'(layerEn), 0);
    checkOutput({tag, ".rd"}, int'(ifmRd), 0);
    checkOutput({tag, ".ifmAddr"}, int'(ifmAddr), 0);
    checkOutput({tag, ".we"}, int'(ofmWe), 0);
    checkOutput({tag, ".ofmAddr"}, int'(ofmAddr), 0);
    checkOutput({tag, ".fb"}, int'(ramFb), 0);
    checkOutput({tag, ".busy"}, int'(busy), 0);
    checkOutput({tag, ".done"}, int'(done), 0);
    checkOutput({tag, ".err"}, int'(err), 0);
  endtask

  // One full pass; expectations come from cycle counts and sample arithmetic.
  task automatic applyStimulus(input logic [31:0] mask, input bit startNoise,
                               output int drainSeen, output int writesSeen,
                               output bit errSeen);
    int  phase, nextPhase, cyc, drainCnt, nSamp, nBefore, slot, expAddr;
    bit  mErr, mWe, smp, expRd;
    phase = PH_RUN; cyc = 0; drainCnt = 0; nSamp = 0; mErr = 1'b0; mWe = 1'b0;
    drainSeen = 0; writesSeen = 0;
    @(negedge clk);
    start_i = 1'b1;
    layer_sample_i = 1'b0;
    @(negedge clk);
    while (phase != PH_IDLE) begin
      slot    = cyc % (K2C + 1);
      expRd   = (phase == PH_RUN) && (slot < K2C);
      expAddr = (phase == PH_RUN) ? (cyc / (K2C + 1)) * K2C + ((slot < K2C) ? slot : K2C - 1)
                                  : modelIfmAddr;
      checkOutput("pass.en", int'(layerEn), int'(phase == PH_RUN));
      checkOutput("pass.rd", int'(ifmRd), int'(expRd));
      checkOutput("pass.ifmAddr", int'(ifmAddr), expAddr);
      checkOutput("pass.we", int'(ofmWe), int'(mWe));
      checkOutput("pass.ofmAddr", int'(ofmAddr), modelOfmAddr);
      checkOutput("pass.fb", int'(ramFb), int'(phase == PH_FB));
      checkOutput("pass.done", int'(done), int'(phase == PH_DONE));
      checkOutput("pass.busy", int'(busy), 1);
      checkOutput("pass.err", int'(err), int'(mErr));
      if (busy && !layerEn && !ramFb && !done) drainSeen++;
      if (ofmWe) writesSeen++;

      smp = (cyc < 32) ? mask[cyc] : 1'b0;
      layer_sample_i = smp;
      start_i = startNoise && (phase == PH_RUN || phase == PH_DRAIN);

      nBefore = nSamp;
      mWe = 1'b0;
      if ((phase == PH_RUN || phase == PH_DRAIN) && smp) begin
        if (nSamp < NPIX) begin
          mWe = 1'b1;
          modelOfmAddr = nSamp;
          nSamp++;
        end else begin
          mErr = 1'b1;
        end
      end
      nextPhase = phase;
      case (phase)
        PH_RUN: if (cyc == NRUN - 1) begin
          nextPhase = PH_DRAIN;
          modelIfmAddr = NPIX * K2C - 1;
        end
        PH_DRAIN: if (nBefore == NPIX) nextPhase = PH_FB;
                  else begin
                    drainCnt++;
                    if (drainCnt == DRAIN_MAX) begin
                      nextPhase = PH_FB;
                      if (nSamp < NPIX) mErr = 1'b1;
                    end
                  end
        PH_FB:   nextPhase = PH_DONE;
        default: nextPhase = PH_IDLE;
      endcase
      phase = nextPhase;
      cyc++;
      @(negedge clk);
    end
    start_i = 1'b0;
    layer_sample_i = 1'b0;
    checkOutput("idle.busy", int'(busy), 0);
    checkOutput("idle.en", int'(layerEn), 0);
    checkOutput("idle.done", int'(done), 0);
    checkOutput("idle.we", int'(ofmWe), int'(mWe));
    checkOutput("idle.ofmAddr", int'(ofmAddr), modelOfmAddr);
    checkOutput("idle.ifmAddr", int'(ifmAddr), modelIfmAddr);
    checkOutput("idle.err", int'(err), int'(mErr));
    errSeen = err;
  endtask

  initial begin
    passVec_t vecs[7];
    int  dSeen, wSeen;
    bit  eSeen;

    vecs[0] = '{mask: 32'h0000_0055, startNoise: 1'b0, expDrain: 1,  expWrites: 4, expErr: 1'b0};
    vecs[1] = '{mask: 32'h0000_002A, startNoise: 1'b0, expDrain: 16, expWrites: 3, expErr: 1'b1};
    vecs[2] = '{mask: 32'h0000_001F, startNoise: 1'b0, expDrain: 1,  expWrites: 4, expErr: 1'b1};
    vecs[3] = '{mask: 32'h0000_1E00, startNoise: 1'b0, expDrain: 6,  expWrites: 4, expErr: 1'b0};
    vecs[4] = '{mask: 32'h0000_0055, startNoise: 1'b1, expDrain: 1,  expWrites: 4, expErr: 1'b0};
    vecs[5] = '{mask: 32'h0000_0655, startNoise: 1'b0, expDrain: 1,  expWrites: 4, expErr: 1'b0};
    vecs[6] = '{mask: 32'h0000_010F, startNoise: 1'b0, expDrain: 1,  expWrites: 4, expErr: 1'b1};

    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    @(negedge clk);
    layer_sample_i = 1'b1;
    @(negedge clk);
    layer_sample_i = 1'b0;
    checkOutput("idleSample.we", int'(ofmWe), 0);
    checkOutput("idleSample.busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].mask, vecs[i].startNoise, dSeen, wSeen, eSeen);
      checkOutput($sformatf("vec%0d.drainCycles", i), dSeen, vecs[i].expDrain);
      checkOutput($sformatf("vec%0d.writes", i), wSeen, vecs[i].expWrites);
      checkOutput($sformatf("vec%0d.err", i), int'(eSeen), int'(vecs[i].expErr));
    end

    for (int r = 0; r < 10; r++) begin
      applyStimulus($urandom() & $urandom(), 1'($urandom_range(0, 1)), dSeen, wSeen, eSeen);
    end

    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort.preEn", int'(layerEn), 1);
    #1 rst_n = 1'b0;
    #1 checkAllZero("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelIfmAddr = 0;
    modelOfmAddr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort.busy", int'(busy), 0);
      checkOutput("abort.done", int'(done), 0);
      checkOutput("abort.fb", int'(ramFb), 0);
    end
    applyStimulus(32'h0000_0055, 1'b0, dSeen, wSeen, eSeen);
    checkOutput("restart.writes", wSeen, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
